cache_mem_model: RTL and testbench
==================================

Name: cache_mem_model

Overview:
Memory-side responder for the direct-mapped cache controller's memory interface.
- Accepts line-granular read and write-back requests (mem_req_type).
- Returns one registered mem_data_type response per request after a fixed latency.
- Backed by a line store; never-written lines return a deterministic address pattern.
- Serves as the bench memory and as a synthesizable memory stub behind the cache.

Parameters:
LATENCY, 4, cycles from request acceptance edge to ready pulse; legal range 1..15
MEM_LINES, 1024, lines of 128 bits in the store; power of two; index = addr[4+$clog2(MEM_LINES)-1:4]

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
mem_req  input  mem_req_type (addr 32, data 128, rw 1, valid 1)  request from the cache; rw=1 is a write
mem_data  output  mem_data_type (data 128, ready 1)  response to the cache; registered
proto_err  output  1  sticky; set when valid arrives while the block cannot accept it

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: mem_data.ready=0, mem_data.data=0, proto_err=0, state=IDLE, latency counter=0.
- Reset also clears the per-line written bitmap. Array contents are not reset.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - On an edge with mem_req.valid=1, capture addr, data and rw.
  - Load counter with LATENCY-1.
  - Go to BUSY; if LATENCY=1, go directly to RESP.
- BUSY: decrement the counter each edge. When it reaches 0, go to RESP and register the response.
- RESP (ready=1 for exactly one cycle):
  - If mem_req.valid=1 in this cycle, accept it as in IDLE and go to BUSY, or to RESP when LATENCY=1.
  - Otherwise go to IDLE.
  - Accepting here is mandatory: the cache raises its allocate request combinationally in the same cycle it sees the write-back ready.
- Latency: a request accepted at edge T gives mem_data.ready=1 during the cycle after edge T+LATENCY-1. That is, ready is visible LATENCY cycles after acceptance. Back-to-back requests have no gap cycle.
- Write (rw=1): on the edge that raises ready, store the captured data at the indexed line and set its bitmap bit. mem_data.data = written data.
- Read (rw=0):
  - If the line's bitmap bit is set, mem_data.data = stored line.
  - Otherwise word j (bits 32j+31:32j) = {captured addr[31:4], j[1:0], 2'b00}, i.e. each word equals its own byte address.
- mem_data.data holds its last value when ready=0.
- Address handling:
  - addr[3:0] is ignored.
  - Bits above the index are ignored for storage, so aliasing wraps modulo MEM_LINES.
  - The unwritten-line pattern uses the full captured address.
- mem_req.valid is ignored in BUSY. If it is 1 there, set proto_err (sticky until rst). The in-flight transaction is unaffected.
- mem_req fields may be X when valid=0 and must not propagate into state.
- Reset mid-transaction: abandon it. No ready pulse, no array write, bitmap cleared.
- Simultaneous rst and valid: reset wins and the request is dropped.

Decomposition:
- cache_def package:
  - Reuse the existing mem_req_type and mem_data_type.
  - Add mem_model_state_type enum {IDLE, BUSY, RESP}.
  - Add localparam MEM_LINE_BITS=128.
- Sub-module mem_line_store:
  - MEM_LINES x 128 array plus written bitmap.
  - Ports: write enable, index, write data, read data, rd_written flag, bitmap clear on rst.
  - Combinational read.
- Top holds the FSM, counter, capture registers, pattern generation, output register and proto_err.

Test Plan:
1. After rst, read addr 0x0000_1230 with LATENCY=4 -> ready=1 exactly 4 cycles after acceptance, for 1 cycle; data = {0x0000_123C, 0x0000_1238, 0x0000_1234, 0x0000_1230}.
2. Write addr 0x0000_0040 with data 0xDEAD..BEEF, then read addr 0x0000_0044 -> read returns 0xDEAD..BEEF; write response data also equals it.
3. Write-back then allocate: valid rw=1 accepted; in its RESP cycle drive valid rw=0, addr 0x0000_2000 -> accepted without an IDLE cycle; second ready exactly 4 cycles later; proto_err stays 0.
4. Assert valid during BUSY -> proto_err=1 and stays 1; the first response is unchanged and on time; the extra request gets no ready.
5. rst pulse 2 cycles into a write to 0x0000_0080 -> no ready pulse; a subsequent read of 0x0000_0080 returns the address pattern, not the write data.
6. MEM_LINES=1024: write 0x4000_0010, then read 0x0000_0010 -> returns the written data (aliasing); LATENCY=1 variant -> ready on the cycle right after acceptance.

Source files
------------

// File: rtl/cache_def.sv
// Shared types for the cache controller and its memory-side model.
package cache_def;

  localparam int MEM_LINE_BITS = 128;
  localparam int MEM_WORDS     = MEM_LINE_BITS / 32;

  typedef struct packed {
    logic [31:0]              addr;
    logic [MEM_LINE_BITS-1:0] data;
    logic                     rw;
    logic                     valid;
  } mem_req_type;

  typedef struct packed {
    logic [MEM_LINE_BITS-1:0] data;
    logic                     ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_model_state_type;

endpackage

// File: rtl/cache_mem_model_line_store.sv
// Line array plus per-line written bitmap; combinational read, bitmap cleared by reset.
module mem_line_store
  import cache_def::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int IDX_W     = $clog2(MEM_LINES)
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         idx_i,
  input  logic [MEM_LINE_BITS-1:0] wr_data_i,
  output logic [MEM_LINE_BITS-1:0] rd_data_o,
  output logic                     rd_written_o
);

  logic [MEM_LINE_BITS-1:0] lines_q [MEM_LINES];
  logic [MEM_LINES-1:0]     written_q;

  // Contents are intentionally left unreset; the bitmap alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_en_i) lines_q[idx_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (clr_i)        written_q        <= '0;
    else if (wr_en_i) written_q[idx_i] <= 1'b1;
  end

  assign rd_data_o    = lines_q[idx_i];
  assign rd_written_o = written_q[idx_i];

endmodule

// File: rtl/cache_mem_model.sv
// Fixed-latency line memory responder for the cache memory port.
module cache_mem_model
  import cache_def::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_LINES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         proto_err
);

  localparam int         IDX_W  = $clog2(MEM_LINES);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         LAT1   = (LATENCY == 1);

  mem_model_state_type state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                accept, resp_fire, perr_set;

  logic [31:4]              addr_q;
  logic [MEM_LINE_BITS-1:0] wdata_q;
  logic                     rw_q;

  logic [MEM_LINE_BITS-1:0] data_q;
  logic                     ready_q;
  logic                     perr_q;

  // With LATENCY=1 the response edge is the acceptance edge, so the
  // transaction is taken straight from the request instead of the capture regs.
  logic [31:4]              txn_addr;
  logic [MEM_LINE_BITS-1:0] txn_data;
  logic                     txn_rw;

  assign txn_addr = LAT1 ? mem_req.addr[31:4] : addr_q;
  assign txn_data = LAT1 ? mem_req.data       : wdata_q;
  assign txn_rw   = LAT1 ? mem_req.rw         : rw_q;

  logic [MEM_LINE_BITS-1:0] st_rdata;
  logic                     st_written;
  logic                     st_we;

  assign st_we = resp_fire & txn_rw & ~rst;

  mem_line_store #(
    .MEM_LINES (MEM_LINES),
    .IDX_W     (IDX_W)
  ) u_store (
    .clk          (clk),
    .clr_i        (rst),
    .wr_en_i      (st_we),
    .idx_i        (txn_addr[4+IDX_W-1:4]),
    .wr_data_i    (txn_data),
    .rd_data_o    (st_rdata),
    .rd_written_o (st_written)
  );

  // Unwritten lines read back as their own word byte addresses.
  logic [MEM_WORDS-1:0][31:0] pat;
  for (genvar j = 0; j < MEM_WORDS; j++) begin : g_pat
    assign pat[j] = {txn_addr[31:4], 2'(j), 2'b00};
  end

  logic [MEM_LINE_BITS-1:0] resp_data;
  assign resp_data = txn_rw     ? txn_data :
                     st_written ? st_rdata : pat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    resp_fire = 1'b0;
    perr_set  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (mem_req.valid) begin
          accept = 1'b1;
          if (LAT1) begin
            state_d   = RESP;
            resp_fire = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        perr_set = mem_req.valid;
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          state_d   = RESP;
          resp_fire = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= mem_req.addr[31:4];
      wdata_q <= mem_req.data;
      rw_q    <= mem_req.rw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      ready_q <= resp_fire;
      if (resp_fire) data_q <= resp_data;
      if (perr_set)  perr_q <= 1'b1;
    end
  end

  assign mem_data  = '{data: data_q, ready: ready_q};
  assign proto_err = perr_q;

endmodule

// File: tb/tb_cache_mem_model.sv
// Scoreboard bench: stimulus pushes expected line + due cycle, monitors pop on ready.
module tb_cache_mem_model;
  import cache_def::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst4, rst1;
  mem_req_type  req4, req1;
  mem_data_type rsp4, rsp1;
  logic         perr4, perr1;

  cache_mem_model #(.LATENCY(4), .MEM_LINES(1024)) u_dut4 (
    .clk(clk), .rst(rst4), .mem_req(req4), .mem_data(rsp4), .proto_err(perr4));
  cache_mem_model #(.LATENCY(1), .MEM_LINES(1024)) u_dut1 (
    .clk(clk), .rst(rst1), .mem_req(req1), .mem_data(rsp1), .proto_err(perr1));

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one request cycle on the selected DUT; push an expectation if wanted.
  task automatic send(input int sel, input logic [31:0] a, input logic [127:0] d,
                      input logic rw, input bit want, input logic [127:0] exp);
    exp_t e;
    e.data = exp;
    if (sel == 4) begin
      req4 = '{addr: a, data: d, rw: rw, valid: 1'b1};
      e.due = cyc + 4;
      if (want) q4.push_back(e);
    end else begin
      req1 = '{addr: a, data: d, rw: rw, valid: 1'b1};
      e.due = cyc + 1;
      if (want) q1.push_back(e);
    end
    @(negedge clk);
    if (sel == 4) req4.valid = 1'b0;
    else          req1.valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() != 0 && cyc > q4[0].due) begin
      e = q4.pop_front();
      chk("missed_ready4", 128'(cyc), 128'(e.due));
    end
    if (rsp4.ready) begin
      if (q4.size() == 0) chk("spurious_ready4", 128'd1, 128'd0);
      else begin
        e = q4.pop_front();
        chk("data4", rsp4.data, e.data);
        chk("latency4", 128'(cyc), 128'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() != 0 && cyc > q1[0].due) begin
      e = q1.pop_front();
      chk("missed_ready1", 128'(cyc), 128'(e.due));
    end
    if (rsp1.ready) begin
      if (q1.size() == 0) chk("spurious_ready1", 128'd1, 128'd0);
      else begin
        e = q1.pop_front();
        chk("data1", rsp1.data, e.data);
        chk("latency1", 128'(cyc), 128'(e.due));
      end
    end
  end

  localparam logic [127:0] D1   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_BEEF;
  localparam logic [127:0] D2   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D3   = 128'hA5A5_A5A5_5A5A_5A5A_F00D_F00D_0BAD_0BAD;
  localparam logic [127:0] D4   = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
  localparam logic [127:0] P1230 = 128'h0000123C_00001238_00001234_00001230;
  localparam logic [127:0] P2000 = 128'h0000200C_00002008_00002004_00002000;
  localparam logic [127:0] P0300 = 128'h0000030C_00000308_00000304_00000300;
  localparam logic [127:0] P0080 = 128'h0000008C_00000088_00000084_00000080;

  initial begin
    rst4 = 1'b1;
    rst1 = 1'b1;
    req4 = '0;
    req1 = '0;
    repeat (3) @(negedge clk);
    rst4 = 1'b0;
    rst1 = 1'b0;
    chk("rst_ready4", 128'(rsp4.ready), 128'd0);
    chk("rst_data4",  rsp4.data, 128'd0);
    chk("rst_perr4",  128'(perr4), 128'd0);
    chk("rst_ready1", 128'(rsp1.ready), 128'd0);

    // Unwritten read pattern
    send(4, 32'h0000_1230, '0, 1'b0, 1'b1, P1230);
    repeat (6) @(negedge clk);

    // Write then read back at a different byte offset of the same line
    send(4, 32'h0000_0040, D1, 1'b1, 1'b1, D1);
    repeat (5) @(negedge clk);
    send(4, 32'h0000_0044, '0, 1'b0, 1'b1, D1);
    repeat (6) @(negedge clk);

    // Write-back immediately followed by allocate in the RESP cycle
    send(4, 32'h0000_0100, D2, 1'b1, 1'b1, D2);
    repeat (3) @(negedge clk);
    send(4, 32'h0000_2000, '0, 1'b0, 1'b1, P2000);
    repeat (6) @(negedge clk);
    chk("b2b_perr4", 128'(perr4), 128'd0);

    // Request during BUSY: flagged, ignored, first response undisturbed
    send(4, 32'h0000_0300, '0, 1'b0, 1'b1, P0300);
    send(4, 32'h0000_0500, '0, 1'b0, 1'b0, '0);
    chk("busy_perr4", 128'(perr4), 128'd1);
    repeat (8) @(negedge clk);
    chk("perr_sticky4", 128'(perr4), 128'd1);

    // Reset mid-write abandons it
    send(4, 32'h0000_0080, D3, 1'b1, 1'b0, '0);
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk("rst_clears_perr4", 128'(perr4), 128'd0);
    repeat (6) @(negedge clk);
    send(4, 32'h0000_0080, '0, 1'b0, 1'b1, P0080);
    repeat (6) @(negedge clk);

    // Request coincident with reset is dropped
    rst4 = 1'b1;
    send(4, 32'h0000_0200, D2, 1'b1, 1'b0, '0);
    rst4 = 1'b0;
    repeat (6) @(negedge clk);

    // Aliasing above the index bits
    send(4, 32'h4000_0010, D4, 1'b1, 1'b1, D4);
    repeat (5) @(negedge clk);
    send(4, 32'h0000_0010, '0, 1'b0, 1'b1, D4);
    repeat (6) @(negedge clk);

    // LATENCY=1 instance
    send(1, 32'h0000_1230, '0, 1'b0, 1'b1, P1230);
    repeat (3) @(negedge clk);
    send(1, 32'h0000_0040, D1, 1'b1, 1'b1, D1);
    send(1, 32'h0000_0048, '0, 1'b0, 1'b1, D1);
    repeat (3) @(negedge clk);
    send(1, 32'h4000_0010, D4, 1'b1, 1'b1, D4);
    send(1, 32'h0000_0010, '0, 1'b0, 1'b1, D4);
    repeat (4) @(negedge clk);
    chk("perr1", 128'(perr1), 128'd0);

    chk("q4_drained", 128'(q4.size()), 128'd0);
    chk("q1_drained", 128'(q1.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
